// File: rtl/video_snoop_engine.sv
// Snoops a video line out of extension RAM during the video half of each Gigatron cycle and drives OUTD.
// Optional build macro VSNOOP_TRANSPARENT_EN: a fetched 6'h00 pixel shows the last CPU (ALU) pixel instead.
module video_snoop_engine #(
  parameter int AW          = 19,
  parameter int LW          = 8,
  parameter int DEFAULT_LEN = 160
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic [1:0]    PHASE,
  input  logic          nOL,
  input  logic [7:0]    ALU,
  input  logic [15:0]   GA,
  input  logic [7:0]    RDIN,
  input  logic          CFG_WE,
  input  logic [15:0]   CFG_DATA,
  output logic [AW-1:0] VRA,
  output logic          VREQ,
  output logic [7:0]    OUTD,
  output logic          BUSY
);
  localparam int BW = AW - 16;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state_reg;
  logic          run_reg;
  logic [BW-1:0] bank_reg;
  logic [1:0]    hrep_reg;
  logic [7:0]    len_reg;
  logic [BW-1:0] line_bank_reg;
  logic [1:0]    line_hrep_reg;
  logic [LW-1:0] line_len_reg;
  logic [15:0]   vaddr_reg;
  logic [LW-1:0] pcnt_reg;
  logic [1:0]    rcnt_reg;
  logic          pix_valid_reg;
  logic [5:0]    pix_reg;
  logic [7:0]    outd_reg;

  logic          run_next;
  logic [BW-1:0] bank_next;
  logic [1:0]    hrep_next;
  logic [7:0]    len_next;
  logic [LW-1:0] eff_len_next;
  logic          output_slot;
  logic          fetch;
  logic          line_start;
  logic          sync_lost;
  logic [5:0]    out_pix;
  logic          unused_bits;

  // A config write landing this cycle is already visible to a line start in the same cycle.
  always_comb begin
    run_next     = CFG_WE ? CFG_DATA[15] : run_reg;
    bank_next    = CFG_WE ? CFG_DATA[12 +: BW] : bank_reg;
    hrep_next    = CFG_WE ? CFG_DATA[11:10] : hrep_reg;
    len_next     = CFG_WE ? CFG_DATA[7:0] : len_reg;
    eff_len_next = (len_next == 8'd0) ? LW'(DEFAULT_LEN) : LW'(len_next);
  end

  assign output_slot = PHASE[0];
  assign fetch       = (state_reg == ACTIVE) && !PHASE[0] && (rcnt_reg == 2'd0) &&
                       !pix_valid_reg && (pcnt_reg < line_len_reg);
  assign line_start  = (state_reg == IDLE) && (PHASE == 2'd1) && !nOL && run_next &&
                       (ALU[7:6] == 2'b11);
  assign sync_lost   = !nOL && (ALU[7:6] != 2'b11);

  assign VRA  = {line_bank_reg, vaddr_reg};
  assign VREQ = fetch;
  assign OUTD = outd_reg;
  assign BUSY = (state_reg == ACTIVE);
  assign unused_bits = ^{CFG_DATA[9:8], RDIN[7:6]};

`ifdef VSNOOP_TRANSPARENT_EN
  logic [5:0] alu_pix_reg;

  assign out_pix = (pix_reg == 6'h00) ? alu_pix_reg : pix_reg;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      alu_pix_reg <= 6'h00;
    end else if (!nOL) begin
      alu_pix_reg <= ALU[5:0];
    end
  end
`else
  assign out_pix = pix_reg;
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg     <= IDLE;
      run_reg       <= 1'b0;
      bank_reg      <= '0;
      hrep_reg      <= 2'd0;
      len_reg       <= 8'd0;
      line_bank_reg <= '0;
      line_hrep_reg <= 2'd0;
      line_len_reg  <= '0;
      vaddr_reg     <= 16'h0000;
      pcnt_reg      <= '0;
      rcnt_reg      <= 2'd0;
      pix_valid_reg <= 1'b0;
      pix_reg       <= 6'h00;
      outd_reg      <= 8'hC0;
    end else begin
      if (CFG_WE) begin
        run_reg  <= CFG_DATA[15];
        bank_reg <= CFG_DATA[12 +: BW];
        hrep_reg <= CFG_DATA[11:10];
        len_reg  <= CFG_DATA[7:0];
      end

      if (!run_next && (state_reg != IDLE)) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if ((PHASE == 2'd1) && !nOL) outd_reg <= ALU;
            if (line_start) begin
              vaddr_reg     <= GA;
              line_bank_reg <= bank_next;
              line_hrep_reg <= hrep_next;
              line_len_reg  <= eff_len_next;
              pcnt_reg      <= '0;
              rcnt_reg      <= 2'd0;
              pix_valid_reg <= 1'b0;
              state_reg     <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (sync_lost) begin
              outd_reg  <= ALU;
              state_reg <= DONE;
            end else begin
              if (!nOL) outd_reg[7:6] <= ALU[7:6];
              if (fetch) begin
                pix_reg       <= RDIN[5:0];
                pix_valid_reg <= 1'b1;
                vaddr_reg     <= vaddr_reg + 16'd1;
                pcnt_reg      <= pcnt_reg + LW'(1);
                rcnt_reg      <= line_hrep_reg;
              end
              // The replica shown with rcnt at zero is the last one of this pixel.
              if (output_slot && pix_valid_reg) begin
                outd_reg[5:0] <= out_pix;
                if (rcnt_reg != 2'd0) begin
                  rcnt_reg <= rcnt_reg - 2'd1;
                end else begin
                  pix_valid_reg <= 1'b0;
                  if (pcnt_reg == line_len_reg) state_reg <= DONE;
                end
              end
            end
          end
          DONE: begin
            if (!nOL) outd_reg <= ALU;
            if ((PHASE == 2'd1) && !nOL && (ALU[7:6] != 2'b11)) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/video_snoop_engine.md
Name: video_snoop_engine

Overview:
- Parametrised video snooping engine. Fetches pixel bytes directly from extension RAM during the video-free half of each Gigatron cycle and drives the VGA output register, so the CPU only has to issue the first OUT of each line.
- Generalises the single-mode snooper with a configurable line length, 1..4x horizontal replication and a RAM bank field.
- Sits between the Gigatron bus decode, the RAM address mux (video slot) and the OUTD register.

Parameters:
- AW, 19: RAM address width. Bank field is AW-16 bits.
- LW, 8: line-length counter width.
- DEFAULT_LEN, 160: line length used when the configured length is 0.

Ports:
- CLK  in  1  4x Gigatron clock (CLKx4 rate); all state on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- PHASE  in  2  quarter of the Gigatron cycle. 0/2 = RAM video slots; 1/3 = output slots; 1 = line-start sample point.
- nOL  in  1  Gigatron OUT-register load strobe, active low.
- ALU  in  8  Gigatron ALU output (sync bits [7:6], pixel [5:0]).
- GA  in  16  Gigatron address bus; holds the line start address when nOL is low.
- RDIN  in  8  RAM read data; valid at the end of a video slot.
- CFG_WE  in  1  one-cycle config write strobe (from the extended ctrl decode).
- CFG_DATA  in  16  config word:
  - [15] RUN
  - [14:12] BANK (low AW-16 bits used)
  - [11:10] HREP (replication = HREP+1)
  - [7:0] LEN
- VRA  out  AW  video RAM address = {BANK, VADDR[15:0]}.
- VREQ  out  1  requests the RAM for the current video slot (enables nROE in the video half).
- OUTD  out  8  VGA output register.
- BUSY  out  1  high while a line is active.

Behaviour:
- Reset values: OUTD=8'hC0 (syncs inactive); VRA=0; VREQ=0; BUSY=0; RUN=0; HREP=0; LEN=0; BANK=0; state IDLE.
- Config: a CFG_WE write updates a shadow register immediately.
  - RUN=0 aborts any active line at once: state goes to IDLE and VREQ=0 on the next CLK.
  - All other fields are copied to the working registers only at line start, so a mid-line write never alters the current line.
- Effective length L = (LEN==0) ? DEFAULT_LEN : LEN.
- State IDLE:
  - On PHASE==1 with nOL low, OUTD <= ALU.
  - If RUN=1, ALU[7:6]==2'b11 and nOL low: VADDR<=GA, pixel count PCNT<=0, replication count RCNT<=0, go to ACTIVE.
- State ACTIVE:
  - VREQ=1 on PHASE 0/2 only when RCNT==0 and PCNT<L.
  - Data is captured at the end of that phase. Then VADDR<=VADDR+1 (16-bit wrap FFFF->0000, bank unchanged), PCNT<=PCNT+1, RCNT<=HREP.
  - Each PHASE 1/3 output slot:
    - OUTD[5:0] <= latest fetched pixel.
    - If RCNT>0, RCNT<=RCNT-1.
  - OUTD[7:6] follows ALU[7:6] whenever nOL is low.
- Line end: go to DONE after the output slot that consumes the last replica of pixel L, or immediately if OUTD[7:6]!=2'b11. Pixel bits then revert to the ALU on the next nOL.
- State DONE: VREQ=0. Return to IDLE after the next PHASE 1 where nOL is low and ALU[7:6]!=2'b11, or after RUN=0.
- First output latency: first pixel appears at the PHASE 3 following line-start detection (one Gigatron cycle after the OUT).
- Simultaneous events:
  - RUN=0 write and line start in the same cycle: no start.
  - CFG_WE and line start in the same cycle: the new fields apply to this line.
- BUSY = (state==ACTIVE).

Optional Feature:
- VSNOOP_TRANSPARENT_EN.
- Defined: a fetched pixel equal to 6'h00 is transparent. OUTD[5:0] instead keeps the last ALU pixel latched on nOL, so CPU-drawn content shows through.
- Undefined: every fetched byte is output verbatim; no extra logic.

Test Plan:
- RUN=1, HREP=0, LEN=4, BANK=3, OUT with ALU=C0h and GA=1234h -> VRA=3_1234..3_1237, OUTD[5:0] = RAM bytes at two per Gigatron cycle, then DONE; exactly 4 VREQ pulses.
- HREP=3, LEN=2, RAM 15h,2Ah -> OUTD[5:0] = 15h x4 slots then 2Ah x4 slots; VREQ asserted only twice.
- GA=FFFEh, LEN=4 -> addresses FFFE, FFFF, 0000, 0001 with bank bits unchanged.
- Mid-line ALU[7:6]=2'b01 on nOL -> line ends that slot, VREQ=0, OUTD follows ALU.
- Mid-line CFG_WE with RUN=0 -> IDLE next CLK, BUSY=0. Mid-line CFG_WE with LEN=2 -> current line keeps its old length; the next line uses 2.
- nRESET low during ACTIVE -> OUTD=C0h, VREQ=0, BUSY=0 immediately; no start until a new RUN=1 write.
